door_idol_tracker: RTL
======================

DOOR_IDOL_TRACKER -- requirements
Module: door_idol_tracker

Interface
REQ-001 Parameter EXIT_FRAMES, default 30, sets the number of frames spent in EXITING before level completion.
REQ-002 clk  input  1  system clock; the single clock domain.
REQ-003 resetN  input  1  reset, asynchronous and active-low.
REQ-004 game_on  input  1  high while a level is being played.
REQ-005 startOfFrame  input  1  one-cycle pulse at the start of each video frame.
REQ-006 topLeftX  input  11  placed object X coordinate, as published by the placement controller.
REQ-007 topLeftY  input  11  placed object Y coordinate, as published by the placement controller.
REQ-008 bitMap_sel  input  1  object type: 0 = door, 1 = idol.
REQ-009 explosion_hit  input  1  level; explosion pixels overlap the object this cycle.
REQ-010 player_hit  input  1  level; player pixels overlap the object this cycle.
REQ-011 enemies_left  input  4  number of live enemies.
REQ-012 object_visible  output  1  draw-request enable for the object bitmap.
REQ-013 door_open  output  1  high in the OPEN state.
REQ-014 idol_collected  output  1  one-cycle pulse when an idol is taken.
REQ-015 level_done  output  1  one-cycle pulse when the level exit completes.
REQ-016 state_dbg  output  3  encoding of the current state.

Function
REQ-017 States SHALL be IDLE=0, HIDDEN=1, REVEALED=2, OPEN=3, EXITING=4 and COLLECTED=5.
REQ-018 IDLE SHALL move to HIDDEN on the first cycle that game_on is high.
REQ-019 HIDDEN SHALL move to REVEALED on the first cycle that explosion_hit is high; object_visible is 0 in HIDDEN.
REQ-020 For a door (bitMap_sel=0), REVEALED SHALL move to OPEN when enemies_left==0.
REQ-021 A door in REVEALED SHALL ignore player_hit.
REQ-022 OPEN SHALL move to EXITING on player_hit.
REQ-023 OPEN SHALL return to REVEALED if enemies_left becomes nonzero (spawn); when both happen in the same cycle, player_hit takes priority.
REQ-024 For an idol (bitMap_sel=1), REVEALED SHALL move to COLLECTED on player_hit and pulse idol_collected for exactly 1 cycle on the transition cycle.
REQ-025 COLLECTED SHALL hold with object_visible=0 until game_on falls.
REQ-026 EXITING SHALL count startOfFrame pulses in a 6-bit counter cleared on entry.
REQ-027 When the counter reaches EXIT_FRAMES, EXITING SHALL pulse level_done for 1 cycle and go to IDLE.
REQ-028 object_visible SHALL be 1 in REVEALED, OPEN and EXITING, and 0 elsewhere.
REQ-029 Registered copies of topLeftX, topLeftY and bitMap_sel SHALL be held.
REQ-030 Any change of topLeftX, topLeftY or bitMap_sel outside IDLE SHALL force HIDDEN on the next cycle and clear the counter; this has priority over every other transition except game_on low.
REQ-031 game_on low in any non-IDLE state SHALL force IDLE next cycle with no level_done pulse and no idol_collected pulse.
REQ-032 explosion_hit in REVEALED, OPEN, EXITING or COLLECTED SHALL have no effect.
REQ-033 Outputs SHALL be registered, with 1-cycle latency from the qualifying input sample.

Reset
REQ-034 On resetN low, asynchronously: state=IDLE, counter=0, all outputs 0, and registered coordinates cleared to 0.
REQ-035 Reset mid-EXITING SHALL suppress level_done.
REQ-036 After reset, the first cycle with game_on high SHALL enter HIDDEN without a coordinate-change restart.

Configuration
REQ-037 With DOOR_BLINK_EN defined, object_visible SHALL toggle every 8 startOfFrame pulses while in OPEN, starting at 1 on OPEN entry, and remain steady 1 in REVEALED and EXITING.
REQ-038 Without DOOR_BLINK_EN, object_visible SHALL be steady 1 in OPEN and no blink counter SHALL be synthesized.

Verification
REQ-039 Door, enemies_left=2, explosion_hit then enemies_left=0 -> state 1 to 2 to 3; door_open=1 one cycle after enemies_left reaches 0.
REQ-040 OPEN, player_hit, EXIT_FRAMES=30 -> level_done pulses 1 cycle on the 30th startOfFrame after entry, then state_dbg=0.
REQ-041 Idol revealed, player_hit held 5 cycles -> idol_collected high exactly 1 cycle, object_visible=0 and state_dbg=5.
REQ-042 In OPEN, topLeftX changes 79 to 143 -> state_dbg=1 and object_visible=0 next cycle.
REQ-043 In EXITING after 10 frames, resetN pulsed low -> all outputs 0 immediately and no level_done pulse afterwards.
REQ-044 OPEN, player_hit and enemies_left=1 in the same cycle -> EXITING; with DOOR_BLINK_EN, object_visible in OPEN shows an 8-on/8-off frame pattern.

Source files
------------

// File: rtl/door_idol_tracker.sv
// Door/idol object tracker: reveal, open, exit and collect sequencing for one placed object.
// Optional build macro DOOR_BLINK_EN: blink the open door every 8 frames.
module door_idol_tracker #(
    parameter int unsigned EXIT_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        game_on,
    input  logic        startOfFrame,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    input  logic        bitMap_sel,
    input  logic        explosion_hit,
    input  logic        player_hit,
    input  logic [3:0]  enemies_left,
    output logic        object_visible,
    output logic        door_open,
    output logic        idol_collected,
    output logic        level_done,
    output logic [2:0]  state_dbg
);

    // state     | meaning
    // IDLE      | no level running
    // HIDDEN    | placed, waiting for an explosion to uncover it
    // REVEALED  | visible; door waits for enemies cleared, idol waits for pickup
    // OPEN      | door open, player may walk through
    // EXITING   | exit animation, counting frames
    // COLLECTED | idol taken, hidden until the level ends
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HIDDEN    = 3'd1,
        REVEALED  = 3'd2,
        OPEN      = 3'd3,
        EXITING   = 3'd4,
        COLLECTED = 3'd5
    } state_t;

    localparam logic [5:0] EXIT_TC = 6'(EXIT_FRAMES);

    state_t      state_q, state_d;
    logic [10:0] x_q, y_q;
    logic        sel_q;
    logic [5:0]  cnt_q, cnt_d, cnt_inc;
    logic        vis_q, vis_d;
    logic        door_q, door_d;
    logic        idol_q, idol_d;
    logic        done_q, done_d;
    logic        coord_change;
    logic        exit_done;
    logic        idol_take;
    logic        open_vis;

    assign coord_change = (topLeftX != x_q) || (topLeftY != y_q) || (bitMap_sel != sel_q);
    assign cnt_inc      = cnt_q + 6'd1;

    // Coordinate copies track the inputs every cycle, so entering HIDDEN never sees a stale mismatch.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= 1'b0;
            vis_q   <= 1'b0;
            door_q  <= 1'b0;
            idol_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= topLeftX;
            y_q     <= topLeftY;
            sel_q   <= bitMap_sel;
            vis_q   <= vis_d;
            door_q  <= door_d;
            idol_q  <= idol_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exit_done = 1'b0;
        idol_take = 1'b0;
        if (state_q != IDLE && !game_on) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q != IDLE && coord_change) begin
            state_d = HIDDEN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (game_on) begin
                        state_d = HIDDEN;
                        cnt_d   = '0;
                    end
                end
                HIDDEN: begin
                    if (explosion_hit) state_d = REVEALED;
                end
                REVEALED: begin
                    if (sel_q) begin
                        if (player_hit) begin
                            state_d   = COLLECTED;
                            idol_take = 1'b1;
                        end
                    end else if (enemies_left == 4'd0) begin
                        state_d = OPEN;
                    end
                end
                OPEN: begin
                    // Player reaching the door wins over a same-cycle enemy spawn.
                    if (player_hit) begin
                        state_d = EXITING;
                        cnt_d   = '0;
                    end else if (enemies_left != 4'd0) begin
                        state_d = REVEALED;
                    end
                end
                EXITING: begin
                    if (startOfFrame) begin
                        if (cnt_inc == EXIT_TC) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            exit_done = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                COLLECTED: begin
                    state_d = COLLECTED;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef DOOR_BLINK_EN
    logic [2:0] blink_cnt_q, blink_cnt_d;
    logic       blink_q, blink_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (state_d == OPEN && state_q != OPEN) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (state_q == OPEN && startOfFrame) begin
            blink_cnt_d = blink_cnt_q + 3'd1;
            if (blink_cnt_q == 3'd7) blink_d = ~blink_q;
        end
    end

    assign open_vis = blink_d;
`else
    assign open_vis = 1'b1;
`endif

    always_comb begin
        vis_d  = 1'b0;
        door_d = 1'b0;
        idol_d = idol_take;
        done_d = exit_done;
        case (state_d)
            REVEALED: vis_d = 1'b1;
            OPEN: begin
                vis_d  = open_vis;
                door_d = 1'b1;
            end
            EXITING: vis_d = 1'b1;
            default: vis_d = 1'b0;
        endcase
    end

    assign object_visible = vis_q;
    assign door_open      = door_q;
    assign idol_collected = idol_q;
    assign level_done     = done_q;
    assign state_dbg      = state_q;

endmodule
